dot_vec_feeder: RTL and testbench
=================================

Name: dot_vec_feeder

Overview:
Upstream stage for the dotProd accumulator. It holds two small operand vectors, A and B, loaded through a write port. On start, it streams matched element pairs onto the accumulator's a/b inputs, one pair per cycle. It pulses an accumulator clear before streaming, drives zeros at all other times so idle cycles add nothing to the sum, and signals done once the last product has had time to settle downstream.

Parameters:
WIDTH, 8, element width; matches the dotProd a/b inputs.
DEPTH, 8, elements per vector buffer.
ADDR_W, 3, buffer address width; equals clog2(DEPTH).
PIPE_LAT, 1, zero-pair drain cycles after the last element, covering downstream latency.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
wr_en  in  1  write strobe for the vector buffers.
wr_addr  in  ADDR_W  element index to write.
wr_a  in  WIDTH  element value for vector A.
wr_b  in  WIDTH  element value for vector B.
start  in  1  begin a streaming run; sampled only in IDLE.
len  in  ADDR_W+1  number of elements to stream; sampled with start.
a_out  out  WIDTH  A operand to dotProd a.
b_out  out  WIDTH  B operand to dotProd b.
acc_clr  out  1  one-cycle pulse that clears the downstream accumulator.
busy  out  1  high while a run is in progress.
done  out  1  one-cycle pulse when the run is complete.
elem_idx  out  ADDR_W  index of the element currently on a_out/b_out.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - a_out=0, b_out=0, acc_clr=0, busy=0, done=0, elem_idx=0.
  - Buffer contents are not reset.
- Register rules:
  - All outputs are registered.
  - Buffer read is synchronous; that latency is hidden inside the state timing below.
- Writes:
  - When wr_en=1 in IDLE, A[wr_addr]<=wr_a and B[wr_addr]<=wr_b.
  - wr_en while busy=1 is ignored, and the buffer is unchanged.
- States: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - Outputs are zero.
  - start=1 at edge E0 latches len_eff = min(len, DEPTH) and moves to CLEAR.
- CLEAR (cycle after E0):
  - acc_clr=1, busy=1, a_out=b_out=0.
  - If len_eff=0, go to DRAIN; otherwise go to STREAM.
- STREAM:
  - For i=0..len_eff-1, the cycle after edge E(1+i) shows a_out=A[i], b_out=B[i], elem_idx=i.
  - After element len_eff-1, go to DRAIN.
- DRAIN:
  - PIPE_LAT cycles with a_out=b_out=0.
  - If PIPE_LAT=0, skip directly to DONE.
- DONE:
  - done=1 and busy=1 for one cycle, then IDLE.
  - busy=0 from the following cycle.
- Latency: start sampled to done asserted = 1 + len_eff + PIPE_LAT + 1 cycles.
- start while busy=1 is ignored, and there is no queuing.
- start and wr_en in the same IDLE cycle: the write completes, and the stream reads the updated value.
- len > DEPTH is clamped to DEPTH. An index never wraps within a run.
- Reset mid-run:
  - Outputs return to zero immediately; no done pulse is produced.
  - The downstream accumulator keeps whatever partial sum it had; the next run's acc_clr discards it.
- No arithmetic is performed in this block; the operands pass through unchanged.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_CLEAR, ST_STREAM, ST_DRAIN, ST_DONE (3-bit);
  - defaults for WIDTH/DEPTH, shared with dotProd.
- One natural sub-module: vec_buf, a DEPTH x (2*WIDTH) register file with one write port and one synchronous read port. The FSM and output registers stay in the top module.

Test Plan:
- Reset: hold reset=0 mid-simulation -> all outputs 0 immediately. Release reset -> IDLE, busy=0.
- Basic run: load A={a3,01,02}, B={24,01,02}, pulse start with len=3.
  - Feeder output: one acc_clr pulse, then pairs (a3,24), (01,01), (02,02) on consecutive cycles, then zeros.
  - done occurs exactly 1+3+PIPE_LAT+1 cycles after start.
  - With dotProd attached, s=16'h16F1 when done is high.
- len=0: start -> acc_clr pulse, no nonzero pairs, done 2+PIPE_LAT cycles after start. Downstream s=0.
- len=12 with DEPTH=8: all 8 elements are streamed, elem_idx goes 0..7, and done follows 1+8+PIPE_LAT+1 cycles after start.
- Ignored inputs during a run:
  - start pulsed again mid-STREAM -> no restart, and done fires once.
  - wr_en mid-run -> buffer unchanged, verified by an identical rerun.
- Reset mid-STREAM, then a fresh run of A={05}, B={03}, len=1 -> new acc_clr; with dotProd attached, s=16'h000F and the stale partial sum is discarded.

Source files
------------

// File: rtl/dot_vec_feeder_pkg.sv
// Shared definitions for the dotProd operand feeder: state encoding and
// element/buffer size defaults common with the dotProd accumulator.
package dot_vec_feeder_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/dot_vec_feeder_vec_buf.sv
// Paired A/B element buffer: one write port and one registered read port.
// The read register doubles as the a_out/b_out output flop and reads zero when idle.
module dot_vec_feeder_vec_buf #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [2*WIDTH-1:0]   wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [2*WIDTH-1:0]   rd_data
);

    logic [2*WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_en ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/dot_vec_feeder.sv
// Streams buffered A/B element pairs into the dotProd accumulator: clear pulse,
// one pair per cycle, zero-pair drain for downstream latency, then a done pulse.
module dot_vec_feeder
    import dot_vec_feeder_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEF_DEPTH),
    parameter int PIPE_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_a,
    input  logic [WIDTH-1:0]    wr_b,
    input  logic                start,
    input  logic [ADDR_W:0]     len,
    output logic [WIDTH-1:0]    a_out,
    output logic [WIDTH-1:0]    b_out,
    output logic                acc_clr,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   elem_idx,
    output logic [2:0]          dbg_state
);

    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam state_t POST_STREAM = (PIPE_LAT == 0) ? ST_DONE : ST_DRAIN;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   idx, idx_n;
    logic [ADDR_W:0]     len_eff, len_eff_n;
    logic [DW-1:0]       drain_cnt, drain_cnt_n;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [2*WIDTH-1:0]  rd_data;
    logic                buf_we;

    assign buf_we = wr_en && (state == ST_IDLE);

    dot_vec_feeder_vec_buf #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_vec_buf (
        .clk     (clk),
        .reset   (reset),
        .we      (buf_we),
        .wr_addr (wr_addr),
        .wr_data ({wr_a, wr_b}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // The read for element i is issued on the edge that enters its display cycle,
    // so the registered read data is already the output operand pair.
    always_comb begin
        state_n     = state;
        idx_n       = '0;
        len_eff_n   = len_eff;
        drain_cnt_n = '0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n   = ST_CLEAR;
                    len_eff_n = (len > LEN_MAX) ? LEN_MAX : len;
                end
            end
            ST_CLEAR: begin
                if (len_eff == '0) begin
                    state_n = POST_STREAM;
                end else begin
                    state_n = ST_STREAM;
                    rd_en   = 1'b1;
                end
            end
            ST_STREAM: begin
                if ({1'b0, idx} == len_eff - 1'b1) begin
                    state_n = POST_STREAM;
                end else begin
                    idx_n   = idx + 1'b1;
                    rd_en   = 1'b1;
                    rd_addr = idx + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DW'(PIPE_LAT - 1)) begin
                    state_n = ST_DONE;
                end else begin
                    drain_cnt_n = drain_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            len_eff   <= '0;
            drain_cnt <= '0;
            acc_clr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            len_eff   <= len_eff_n;
            drain_cnt <= drain_cnt_n;
            acc_clr   <= (state_n == ST_CLEAR);
            busy      <= (state_n != ST_IDLE);
            done      <= (state_n == ST_DONE);
        end
    end

    assign a_out     = rd_data[2*WIDTH-1:WIDTH];
    assign b_out     = rd_data[WIDTH-1:0];
    assign elem_idx  = idx;
    assign dbg_state = state;

endmodule

// File: tb/tb_dot_vec_feeder.sv
// Self-checking bench for dot_vec_feeder with a behavioural dotProd accumulator
// model and a queue of expected operand pairs.
module tb_dot_vec_feeder;
    import dot_vec_feeder_pkg::*;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AW = 3;
    localparam int PL = 1;
    localparam int PW = 2*W + AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_a, wr_b;
    logic          start;
    logic [AW:0]   len;
    logic [W-1:0]  a_out, b_out;
    logic          acc_clr, busy, done;
    logic [AW-1:0] elem_idx;
    logic [2:0]    dbg_state;

    int            n_vec = 0;
    int            n_err = 0;
    int            clr_cnt, done_cnt;
    logic [15:0]   acc_s = '0;
    logic [W-1:0]  ma [D];
    logic [W-1:0]  mb [D];
    logic [PW-1:0] exp_q [$];

    typedef struct {
        int          len;
        int          lat;
        logic [15:0] s;
    } vec_t;
    vec_t tbl [5];

    dot_vec_feeder #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .PIPE_LAT(PL)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_a      (wr_a),
        .wr_b      (wr_b),
        .start     (start),
        .len       (len),
        .a_out     (a_out),
        .b_out     (b_out),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .done      (done),
        .elem_idx  (elem_idx),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge, update the accumulator model and scoreboard.
    task automatic tick();
        logic [PW-1:0] e;
        @(posedge clk);
        #1;
        if (acc_clr) clr_cnt++;
        if (done) done_cnt++;
        if (acc_clr) acc_s = '0;
        else acc_s = acc_s + ({8'b0, a_out} * {8'b0, b_out});
        if (dbg_state == ST_STREAM) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL stream_extra: got pair %0h with no expected pair", {a_out, b_out, elem_idx});
            end else begin
                e = exp_q.pop_front();
                check("pair", 64'({a_out, b_out, elem_idx}), 64'(e));
            end
        end else begin
            check("zero_pair", 64'({a_out, b_out}), 64'(0));
        end
    endtask

    task automatic write(input int addr, input logic [W-1:0] a, input logic [W-1:0] b);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_a    = a;
        wr_b    = b;
        tick();
        wr_en   = 1'b0;
        ma[addr] = a;
        mb[addr] = b;
    endtask

    task automatic push_pairs(input int le);
        for (int i = 0; i < le; i++) exp_q.push_back({ma[i], mb[i], AW'(i)});
    endtask

    task automatic run(input int len_in, input int exp_lat, input logic [15:0] exp_s,
                       input int restart_at, input int wr_at);
        int le;
        int n;
        le = (len_in > D) ? D : len_in;
        push_pairs(le);
        clr_cnt  = 0;
        done_cnt = 0;
        start = 1'b1;
        len   = (AW+1)'(len_in);
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        n = 1;
        check("acc_clr_first", 64'(acc_clr), 64'(1));
        check("busy_run", 64'(busy), 64'(1));
        while (!done && n < 100) begin
            start = (n == restart_at);
            wr_en = (n == wr_at);
            wr_addr = '0;
            wr_a = 8'hff;
            wr_b = 8'hff;
            tick();
            n++;
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected %0d", n, exp_lat);
        end else begin
            check("done_lat", 64'(n), 64'(exp_lat));
        end
        check("sum", 64'(acc_s), 64'(exp_s));
        check("busy_at_done", 64'(busy), 64'(1));
        check("q_left", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        tick();
        check("busy_after", 64'(busy), 64'(0));
        check("done_after", 64'(done), 64'(0));
        repeat (2) tick();
        check("clr_pulses", 64'(clr_cnt), 64'(1));
        check("done_pulses", 64'(done_cnt), 64'(1));
    endtask

    initial begin
        logic [15:0] s;
        int          rl;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
        start = 1'b0; len = '0;
        clr_cnt = 0; done_cnt = 0;

        // Asynchronous reset: outputs must clear without a clock edge.
        #2 reset = 1'b0;
        #1;
        check("rst_outputs", 64'({a_out, b_out, acc_clr, busy, done, elem_idx}), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tick();
        check("idle_busy", 64'(busy), 64'(0));

        write(0, 8'ha3, 8'h24); write(1, 8'h01, 8'h01); write(2, 8'h02, 8'h02);
        write(3, 8'h10, 8'h01); write(4, 8'h20, 8'h02); write(5, 8'h30, 8'h03);
        write(6, 8'h40, 8'h04); write(7, 8'h50, 8'h05);

        // Latency = 1 + len_eff + PIPE_LAT + 1, len clamped to DEPTH.
        tbl[0] = '{len: 3,  lat: 6,  s: 16'h16F1};
        tbl[1] = '{len: 0,  lat: 3,  s: 16'h0000};
        tbl[2] = '{len: 12, lat: 11, s: 16'h1A61};
        tbl[3] = '{len: 8,  lat: 11, s: 16'h1A61};
        tbl[4] = '{len: 1,  lat: 4,  s: 16'h16EC};
        for (int t = 0; t < 5; t++) run(tbl[t].len, tbl[t].lat, tbl[t].s, -1, -1);

        // start pulsed mid-stream is ignored.
        run(5, 8, 16'h1741, 3, -1);

        // Write mid-run ignored, then an identical rerun sees the original buffer.
        run(8, 11, 16'h1A61, -1, 4);
        run(8, 11, 16'h1A61, -1, -1);

        // Write in the same cycle as start is seen by the stream.
        ma[0] = 8'h77; mb[0] = 8'h02;
        wr_en = 1'b1; wr_addr = '0; wr_a = 8'h77; wr_b = 8'h02;
        run(1, 4, 16'h00EE, -1, -1);
        write(0, 8'ha3, 8'h24);

        // Reset mid-stream, then a fresh single-element run discards the stale sum.
        push_pairs(D);
        clr_cnt = 0;
        start = 1'b1; len = 4'd8;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #3 reset = 1'b0;
        #1;
        check("midrst_outputs", 64'({a_out, b_out, acc_clr, busy, done, elem_idx}), 64'(0));
        check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        done_cnt = 0;
        tick();
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_no_done", 64'(done_cnt), 64'(0));
        write(0, 8'h05, 8'h03);
        run(1, 4, 16'h000F, -1, -1);

        // Random buffer contents and lengths.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < D; i++) write(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            rl = $urandom_range(0, 12);
            s = '0;
            for (int i = 0; i < ((rl > D) ? D : rl); i++) s = s + ({8'b0, ma[i]} * {8'b0, mb[i]});
            run(rl, 1 + ((rl > D) ? D : rl) + PL + 1, s, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
